// File: rtl/rps_draw_ctrl_if.sv
// rps_draw_ctrl_if
// Bundles every signal between the draw controller and the outside world
// (game FSM requesters, glyph ROMs, vga_adapter). Clock and reset stay as
// plain ports on the controller.
//
// Handshake rules:
//   req_user / req_comp / clear_req are level requests. A requester holds its
//   line high until it sees the matching one-cycle gnt_* pulse. The controller
//   samples requests only while idle, so a line still high after `done` is
//   treated as a fresh request. vga_plot is a valid strobe with no ready: the
//   adapter accepts exactly one pixel (vga_x, vga_y, vga_colour) on every
//   rising edge of the clock where vga_plot is high.
//
// Signals:
//   req_user, choice_user[1:0]  user sprite request and glyph choice
//   req_comp, choice_comp[1:0]  computer sprite request and glyph choice
//   clear_req                   full-screen clear request
//   gnt_user/gnt_comp/gnt_clear one-cycle acceptance pulses
//   busy, done                  operation in progress / last-pixel pulse
//   rom_addr[11:0], rom_sel[1:0], rom_q   glyph ROM port
//   vga_x[7:0], vga_y[6:0], vga_colour[2:0], vga_plot   pixel write port
//   state_dbg[1:0]              controller state (0 IDLE, 1 CLEAR, 2 DRAW, 3 FLUSH)
interface rps_draw_ctrl_if;
  logic        req_user;
  logic [1:0]  choice_user;
  logic        req_comp;
  logic [1:0]  choice_comp;
  logic        clear_req;
  logic        gnt_user;
  logic        gnt_comp;
  logic        gnt_clear;
  logic        busy;
  logic        done;
  logic [11:0] rom_addr;
  logic [1:0]  rom_sel;
  logic        rom_q;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [1:0]  state_dbg;

  // master: requesters, ROM and adapter side
  modport master (
    output req_user, choice_user, req_comp, choice_comp, clear_req, rom_q,
    input  gnt_user, gnt_comp, gnt_clear, busy, done, rom_addr, rom_sel,
           vga_x, vga_y, vga_colour, vga_plot, state_dbg
  );

  // slave: the draw controller
  modport slave (
    input  req_user, choice_user, req_comp, choice_comp, clear_req, rom_q,
    output gnt_user, gnt_comp, gnt_clear, busy, done, rom_addr, rom_sel,
           vga_x, vga_y, vga_colour, vga_plot, state_dbg
  );
endinterface

// File: rtl/rps_draw_ctrl.sv
// rps_draw_ctrl
// Shares the single vga_adapter plot port between a user sprite, a computer
// sprite and a full-screen clear. Sprites are read from a glyph ROM with
// ROM_LAT cycles of latency; pixel coordinates travel alongside in a shift
// register so each ROM bit meets its own (x, y). One pixel per cycle.
//
// Ports:
//   CLOCK_50  system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       rps_draw_ctrl_if.slave (requests, grants, ROM port, pixel port,
//             state_dbg)
module rps_draw_ctrl #(
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 64,
  parameter int ROM_LAT  = 2,
  parameter int USER_X0  = 8,
  parameter int COMP_X0  = 88,
  parameter int SPR_Y0   = 28
) (
  input  logic           CLOCK_50,
  input  logic           reset_n,
  rps_draw_ctrl_if.slave bus
);

  localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t         state;
  logic [7:0]     sx;
  logic [6:0]     sy;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic [1:0]     fcnt;
  logic [11:0]    rom_addr;
  logic [1:0]     rom_sel;
  logic [7:0]     base_x;
  logic           owner_comp;
  // Round-robin pointer. 1: computer was served last, user wins a tie.
  // 0 (reset): user was served last, computer wins a tie.
  logic           last_comp;

  // Pixel pipeline, stage ROM_LAT-1 lines up with rom_q.
  logic           pv [ROM_LAT];
  logic [7:0]     px [ROM_LAT];
  logic [6:0]     py [ROM_LAT];

  logic start_clear;
  logic start_comp;
  logic start_user;
  logic last_addr;

  // Grants are decided in the IDLE cycle itself so the pulse coincides with
  // the state leaving IDLE. Gating with reset_n keeps them low under reset
  // even though requests may be high.
  assign start_clear = reset_n && (state == IDLE) && bus.clear_req;
  assign start_comp  = reset_n && (state == IDLE) && !bus.clear_req &&
                       bus.req_comp && (!bus.req_user || !last_comp);
  assign start_user  = reset_n && (state == IDLE) && !bus.clear_req &&
                       bus.req_user && (!bus.req_comp || last_comp);

  assign last_addr = (cx == CXW'(SPRITE_W - 1)) && (cy == CYW'(SPRITE_H - 1));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sx         <= '0;
      sy         <= '0;
      cx         <= '0;
      cy         <= '0;
      fcnt       <= '0;
      rom_addr   <= '0;
      rom_sel    <= '0;
      base_x     <= '0;
      owner_comp <= 1'b0;
      last_comp  <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pv[i] <= 1'b0;
        px[i] <= '0;
        py[i] <= '0;
      end
    end else begin
      // The address on rom_addr this cycle belongs to (base_x+cx, SPR_Y0+cy).
      pv[0] <= (state == DRAW);
      px[0] <= base_x + 8'(cx);
      py[0] <= 7'(SPR_Y0) + 7'(cy);
      for (int i = 1; i < ROM_LAT; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end

      case (state)
        IDLE: begin
          if (start_clear) begin
            state <= CLEAR;
            sx    <= '0;
            sy    <= '0;
          end else if (start_comp || start_user) begin
            state      <= DRAW;
            owner_comp <= start_comp;
            last_comp  <= start_comp;
            rom_sel    <= start_comp ? bus.choice_comp : bus.choice_user;
            base_x     <= start_comp ? 8'(COMP_X0) : 8'(USER_X0);
            cx         <= '0;
            cy         <= '0;
            rom_addr   <= '0;
          end
        end
        CLEAR: begin
          if (sx == 8'd159) begin
            sx <= '0;
            if (sy == 7'd119) begin
              sy    <= '0;
              state <= IDLE;
            end else begin
              sy <= sy + 7'd1;
            end
          end else begin
            sx <= sx + 8'd1;
          end
        end
        DRAW: begin
          rom_addr <= rom_addr + 12'd1;
          if (cx == CXW'(SPRITE_W - 1)) begin
            cx <= '0;
            cy <= last_addr ? '0 : cy + CYW'(1);
          end else begin
            cx <= cx + CXW'(1);
          end
          if (last_addr) begin
            state <= FLUSH;
            fcnt  <= '0;
          end
        end
        FLUSH: begin
          if (fcnt == 2'(ROM_LAT - 1)) begin
            state <= IDLE;
          end else begin
            fcnt <= fcnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic       plot_o;
  logic [7:0] x_o;
  logic [6:0] y_o;
  logic [2:0] colour_o;

  // Clear pixels come straight from the counters; sprite pixels come from the
  // pipeline tail paired with the ROM bit that has just become valid.
  always_comb begin
    plot_o   = 1'b0;
    x_o      = '0;
    y_o      = '0;
    colour_o = 3'b000;
    if (state == CLEAR) begin
      plot_o = 1'b1;
      x_o    = sx;
      y_o    = sy;
    end else if (pv[ROM_LAT-1]) begin
      plot_o   = 1'b1;
      x_o      = px[ROM_LAT-1];
      y_o      = py[ROM_LAT-1];
      colour_o = bus.rom_q ? (owner_comp ? 3'b111 : 3'b000) : 3'b010;
    end
  end

  assign bus.gnt_clear  = start_clear;
  assign bus.gnt_comp   = start_comp;
  assign bus.gnt_user   = start_user;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = ((state == CLEAR) && (sx == 8'd159) && (sy == 7'd119)) ||
                          ((state == FLUSH) && (fcnt == 2'(ROM_LAT - 1)));
  assign bus.rom_addr   = rom_addr;
  assign bus.rom_sel    = rom_sel;
  assign bus.vga_plot   = plot_o;
  assign bus.vga_x      = x_o;
  assign bus.vga_y      = y_o;
  assign bus.vga_colour = colour_o;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_rps_draw_ctrl.sv
// tb_rps_draw_ctrl
// Directed bench for rps_draw_ctrl. Every grant, plot and done is an event;
// the stimulus pushes the expected event words, the monitor pops and compares
// on each falling edge where the DUT shows any event. The event word also
// carries the cycle gap since the previous event (saturating at 15), which
// pins down latency, bubbles and the single IDLE cycle between operations.
module tb_rps_draw_ctrl;
  localparam int ROM_LAT = 2;
  localparam int SPR_N   = 64 * 64;
  localparam int CLR_N   = 160 * 120;

  // ---------------- clock / reset ----------------
  logic CLOCK_50 = 1'b0;
  logic reset_n;
  always #10 CLOCK_50 = ~CLOCK_50;

  rps_draw_ctrl_if bus();

  rps_draw_ctrl #(
    .SPRITE_W(64), .SPRITE_H(64), .ROM_LAT(ROM_LAT),
    .USER_X0(8), .COMP_X0(88), .SPR_Y0(28)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // ---------------- glyph ROM model ----------------
  int          rom_mode = 0;
  logic [11:0] a_d [ROM_LAT];

  always @(posedge CLOCK_50) begin
    a_d[0] <= bus.rom_addr;
    for (int i = 1; i < ROM_LAT; i++) a_d[i] <= a_d[i-1];
  end

  function automatic logic rom_f(input int mode, input int a);
    case (mode)
      0:       return (a == 0);
      1:       return 1'b1;
      default: return ((a ^ (a >> 6) ^ (a >> 9)) & 1) != 0;
    endcase
  endfunction

  assign bus.rom_q = rom_f(rom_mode, int'(a_d[ROM_LAT-1]));

  // ---------------- scoreboard ----------------
  // {gap[3:0], gnt_clear, gnt_comp, gnt_user, done, plot, sel[1:0], col[2:0], x[7:0], y[6:0]}
  logic [28:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_events = 0;
  int gap      = 15;

  function automatic logic [28:0] mk(input int g, input logic gc, input logic gm,
                                     input logic gu, input logic dn, input logic pl,
                                     input logic [1:0] sel, input logic [2:0] col,
                                     input int x, input int y);
    return {4'(g), gc, gm, gu, dn, pl, sel, col, 8'(x), 7'(y)};
  endfunction

  function automatic string fmt(input logic [28:0] w);
    return $sformatf("gap=%0d gnt(clr/comp/user)=%b%b%b done=%b plot=%b sel=%b col=%b x=%0d y=%0d",
                     w[28:25], w[24], w[23], w[22], w[21], w[20], w[19:18], w[17:15],
                     w[14:7], w[6:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    else n_pass++;
  endtask

  task automatic push_grant(input int who, input int g);
    exp_q.push_back(mk(g, who == 2, who == 1, who == 0, 1'b0, 1'b0, 2'b00, 3'b000, 0, 0));
  endtask

  task automatic push_sprite(input bit comp, input logic [1:0] sel, input int mode,
                             input int count);
    for (int i = 0; i < count; i++) begin
      int cx;
      int cy;
      logic [2:0] col;
      cx  = i % 64;
      cy  = i / 64;
      col = rom_f(mode, i) ? (comp ? 3'b111 : 3'b000) : 3'b010;
      exp_q.push_back(mk((i == 0) ? ROM_LAT + 1 : 1, 1'b0, 1'b0, 1'b0, i == SPR_N - 1,
                         1'b1, sel, col, (comp ? 88 : 8) + cx, 28 + cy));
    end
  endtask

  task automatic push_clear(input logic [1:0] sel);
    for (int i = 0; i < CLR_N; i++) begin
      exp_q.push_back(mk(1, 1'b0, 1'b0, 1'b0, i == CLR_N - 1, 1'b1, sel, 3'b000,
                         i % 160, i / 160));
    end
  endtask

  // monitor
  always @(negedge CLOCK_50) begin
    logic [28:0] got;
    logic [28:0] exp;
    if (gap < 15) gap++;
    if (bus.gnt_clear || bus.gnt_comp || bus.gnt_user || bus.done || bus.vga_plot) begin
      got = mk(gap, bus.gnt_clear, bus.gnt_comp, bus.gnt_user, bus.done, bus.vga_plot,
               bus.vga_plot ? bus.rom_sel : 2'b00, bus.vga_plot ? bus.vga_colour : 3'b000,
               bus.vga_plot ? int'(bus.vga_x) : 0, bus.vga_plot ? int'(bus.vga_y) : 0);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL event %0d unexpected: got %s", n_events, fmt(got));
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL event %0d: got %s | expected %s", n_events, fmt(got), fmt(exp));
        else n_pass++;
      end
      n_events++;
      gap = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after a rising edge once the queue has drained to target.
  task automatic wait_q(input int target, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(posedge CLOCK_50);
      n++;
    end while (exp_q.size() > target && n < budget);
    n_checks++;
    if (exp_q.size() > target) begin
      $display("FAIL %s: timeout with %0d events outstanding, expected at most %0d",
               name, exp_q.size(), target);
      exp_q.delete();
    end else begin
      n_pass++;
    end
  endtask

  // Request raised just after a rising edge; grant is seen in that same cycle.
  task automatic request(input int who);
    if (who == 0) bus.req_user = 1'b1;
    else bus.req_comp = 1'b1;
    @(negedge CLOCK_50);
    chk("busy_in_grant_cycle", 32'(bus.busy), 32'd0);
    @(posedge CLOCK_50);
    #1;
    if (who == 0) bus.req_user = 1'b0;
    else bus.req_comp = 1'b0;
    chk("busy_after_grant", 32'(bus.busy), 32'd1);
  endtask

  task automatic idle_gap();
    repeat (20) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic finish_op(input string name);
    wait_q(0, 6000, name);
    #1;
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n         = 1'b0;
    bus.req_user    = 1'b1;
    bus.req_comp    = 1'b1;
    bus.clear_req   = 1'b1;
    bus.choice_user = 2'b00;
    bus.choice_comp = 2'b00;

    // Reset with every request high: everything stays quiet.
    repeat (4) @(negedge CLOCK_50);
    chk("rst_gnt_user", 32'(bus.gnt_user), 32'd0);
    chk("rst_gnt_comp", 32'(bus.gnt_comp), 32'd0);
    chk("rst_gnt_clear", 32'(bus.gnt_clear), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_plot", 32'(bus.vga_plot), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_rom_sel", 32'(bus.rom_sel), 32'd0);
    chk("rst_vga_x", 32'(bus.vga_x), 32'd0);
    chk("rst_vga_y", 32'(bus.vga_y), 32'd0);
    chk("rst_colour", 32'(bus.vga_colour), 32'd0);
    chk("rst_state", 32'(bus.state_dbg), 32'd0);

    // Release: clear wins over both sprite requests.
    @(posedge CLOCK_50);
    #1;
    push_grant(2, 15);
    push_clear(2'b00);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    chk("busy_in_grant_cycle", 32'(bus.busy), 32'd0);
    @(posedge CLOCK_50);
    #1;
    bus.clear_req = 1'b0;
    bus.req_user  = 1'b0;
    bus.req_comp  = 1'b0;
    chk("busy_after_grant", 32'(bus.busy), 32'd1);
    wait_q(0, 20000, "reset_clear");
    #1;
    chk("busy_after_done", 32'(bus.busy), 32'd0);

    // User sprite, ROM bit set only at address 0.
    idle_gap();
    rom_mode        = 0;
    bus.choice_user = 2'b01;
    push_grant(0, 15);
    push_sprite(1'b0, 2'b01, 0, SPR_N);
    request(0);
    chk("first_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rom_sel_latched", 32'(bus.rom_sel), 32'd1);
    @(posedge CLOCK_50);
    #1;
    chk("second_rom_addr", 32'(bus.rom_addr), 32'd1);
    finish_op("user_sprite");

    // Round-robin: comp, user, comp with both held high.
    idle_gap();
    rom_mode        = 2;
    bus.choice_user = 2'b00;
    bus.choice_comp = 2'b11;
    push_grant(1, 15);
    push_sprite(1'b1, 2'b11, 2, SPR_N);
    push_grant(0, 1);
    push_sprite(1'b0, 2'b00, 2, SPR_N);
    push_grant(1, 1);
    push_sprite(1'b1, 2'b11, 2, SPR_N);
    bus.req_user = 1'b1;
    bus.req_comp = 1'b1;
    wait_q(SPR_N, 15000, "rr_grants");
    #1;
    bus.req_user = 1'b0;
    bus.req_comp = 1'b0;
    finish_op("rr_last_draw");

    // Computer sprite, ROM all ones, choice toggles mid-draw.
    idle_gap();
    rom_mode        = 1;
    bus.choice_comp = 2'b10;
    push_grant(1, 15);
    push_sprite(1'b1, 2'b10, 1, SPR_N);
    request(1);
    bus.choice_comp = 2'b01;
    repeat (700) @(posedge CLOCK_50);
    #1;
    bus.choice_comp = 2'b11;
    chk("rom_sel_frozen", 32'(bus.rom_sel), 32'd2);
    finish_op("comp_sprite");

    // Clear requested during a user draw, computer waiting behind it.
    idle_gap();
    rom_mode        = 2;
    bus.choice_user = 2'b01;
    bus.choice_comp = 2'b00;
    push_grant(0, 15);
    push_sprite(1'b0, 2'b01, 2, SPR_N);
    push_grant(2, 1);
    push_clear(2'b01);
    push_grant(1, 1);
    push_sprite(1'b1, 2'b00, 2, SPR_N);
    request(0);
    repeat (100) @(posedge CLOCK_50);
    #1;
    bus.clear_req = 1'b1;
    bus.req_comp  = 1'b1;
    wait_q(CLR_N + 1 + SPR_N, 6000, "clear_grant");
    #1;
    bus.clear_req = 1'b0;
    wait_q(SPR_N, 20000, "comp_after_clear");
    #1;
    bus.req_comp = 1'b0;
    finish_op("clear_priority");

    // Reset after 1000 plots: abort, no done, restart from (8,28).
    idle_gap();
    rom_mode        = 2;
    bus.choice_user = 2'b10;
    push_grant(0, 15);
    push_sprite(1'b0, 2'b10, 2, 1000);
    request(0);
    wait_q(0, 2000, "plots_before_reset");
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_plot", 32'(bus.vga_plot), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
    chk("abort_rom_sel", 32'(bus.rom_sel), 32'd0);
    idle_gap();
    push_grant(0, 15);
    push_sprite(1'b0, 2'b10, 2, SPR_N);
    request(0);
    finish_op("restart_draw");

    repeat (5) @(posedge CLOCK_50);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(20 * 110000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rps_draw_ctrl.md
# rps_draw_ctrl

Sequencer and arbiter for the 160x120 VGA pixel-write path. It shares the single `vga_adapter` plot port between two sprite requesters (user and computer) and a full-screen clear. It drives the glyph ROM address and select, aligns ROM latency with pixel coordinates, and emits one pixel per cycle. It sits between the game FSM and the rock/scissor/paper ROMs plus `vga_adapter`.

## Interface
Parameters:
- SPRITE_W, 64, sprite width in pixels (power of two)
- SPRITE_H, 64, sprite height in pixels
- ROM_LAT, 2, cycles from rom_addr change to valid rom_q (range 1..4)
- USER_X0, 8, left x of the user sprite
- COMP_X0, 88, left x of the computer sprite
- SPR_Y0, 28, top y of both sprites

Ports:
- CLOCK_50  in  1  system clock, all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_user  in  1  level request: draw the user sprite
- choice_user  in  2  00 rock, 01 scissor, 10/11 paper
- req_comp  in  1  level request: draw the computer sprite
- choice_comp  in  2  same encoding as choice_user
- clear_req  in  1  level request: paint the full screen black
- gnt_user  out  1  one-cycle pulse when the user request is accepted
- gnt_comp  out  1  one-cycle pulse when the computer request is accepted
- gnt_clear  out  1  one-cycle pulse when the clear request is accepted
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse after the last pixel of an operation
- rom_addr  out  12  glyph ROM address, row-major: cy*SPRITE_W+cx
- rom_sel  out  2  latched choice, steers the ROM output mux
- rom_q  in  1  selected ROM data bit, valid ROM_LAT cycles after its address
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel RGB
- vga_plot  out  1  write strobe to vga_adapter

## Operation
- States: IDLE, CLEAR, DRAW, FLUSH.
- **IDLE.** Requests are sampled every cycle.
  - clear_req has absolute priority: pulse gnt_clear and go to CLEAR.
  - Otherwise the user/computer requests are arbitrated round-robin. A `last` flag (reset 0 = computer) gives priority to the requester not served last.
  - On a grant: pulse the gnt_* line, latch the owner, latch the choice into rom_sel, set base x to USER_X0 or COMP_X0, then go to DRAW.
- **CLEAR.**
  - Counters sx 0..159 and sy 0..119, x wraps at 159 to 0 and increments y.
  - Outputs plot=1, colour 3'b000, x=sx, y=sy. No ROM involvement.
  - After (159,119) is plotted: pulse done and go to IDLE. This takes 19200 plot cycles.
- **DRAW.**
  - Counters cx 0..SPRITE_W-1 and cy 0..SPRITE_H-1. One address is issued per cycle.
  - A valid bit and (base_x+cx, SPR_Y0+cy) enter a ROM_LAT-deep shift register.
  - After address (SPRITE_W-1, SPRITE_H-1) is issued, go to FLUSH.
- **FLUSH.**
  - Lasts ROM_LAT cycles while the pipeline drains.
  - Pulse done together with the last plot cycle, then go to IDLE.
- Pixel colour is computed when the delayed valid bit is 1, paired with rom_q:
  - rom_q=1: 3'b000 if the owner is user, 3'b111 if the owner is computer.
  - rom_q=0: 3'b010 (green).
- vga_plot equals the delayed valid bit. vga_x/vga_y come from the shift-register tail.
- rom_sel and the owner stay frozen from grant until IDLE; choice input changes mid-draw are ignored.
- Requests are not queued. A requester still high in IDLE after its done is re-arbitrated, and round-robin gives the other requester priority.
- Coordinate arithmetic is 8-bit x and 7-bit y. Parameters must keep sprites on screen; no clipping logic is required.

## Timing
- Reset values (asynchronous): state IDLE, all counters 0, shift-register valid bits 0, last=0.
  - gnt_*, busy, done, vga_plot: 0.
  - rom_addr, rom_sel, vga_x, vga_y, vga_colour: 0.
- Reset asserted mid-operation aborts it. vga_plot drops to 0 asynchronously, no done pulse is emitted, and the next operation starts from IDLE.
- Grant pulse occurs in the cycle the state leaves IDLE. busy rises the next cycle.
- DRAW: first rom_addr=0 is driven in the first DRAW cycle. The first vga_plot occurs ROM_LAT cycles later.
- One sprite takes SPRITE_W*SPRITE_H consecutive plot cycles with no bubbles.
- Total latency from grant to done is SPRITE_W*SPRITE_H+ROM_LAT cycles.
- After done, busy falls in the following cycle. Back-to-back grants are possible: one IDLE cycle between operations.
- clear_req asserted during DRAW does not preempt the draw; it is served at the next IDLE.

## Test plan
- **Reset:** hold reset_n=0 with all requests high. All outputs stay 0. Release reset: gnt_clear pulses first.
- **User sprite:** req_user=1, choice_user=01, ROM model returns 1 at address 0 only. Required response:
  - gnt_user pulses; rom_sel=01.
  - First plot at (8,28) with colour 000; the second plot at (9,28) is 010.
  - Exactly 4096 plots, ending at (71,91); done pulses on the last plot.
- **Round-robin:** req_user and req_comp both held high. Grants alternate comp, user, comp (last=0 at reset), with a single IDLE cycle between each done and the next grant.
- **Computer sprite colour:** req_comp with choice 10 and rom_q=1 everywhere. All 4096 plots are 111, x spans 88..151; rom_sel stays 10 even if choice_comp toggles mid-draw.
- **Clear priority:** assert clear_req during a user draw. The draw completes its 4096 plots, then gnt_clear pulses ahead of a pending req_comp. Exactly 19200 black plots follow, ending at (159,119).
- **Mid-draw reset:** pull reset_n low at plot 1000. vga_plot=0 immediately and no done pulse. After release, req_user restarts the draw from (8,28).
